alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle, handshaked ALU command unit. It accepts one operation through a valid/ready request port and returns the result through a valid/ready response port.
- It uses the team's standard 2-bit op encoding: 00 arithmetic shift right by inC, 01 logical shift right, 10 A-B, 11 A+B.
- Add and subtract complete in one step. Shifts execute iteratively, one bit per clock.
- Sits between a command producer (sequencer or bus bridge) and a result consumer. It also adds a carry/borrow/shift-out flag.

Parameters:
- WIDTH, 4, operand and result width in bits.
- SHW, 2, width of the shift-amount field inC.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  request ready; high only in IDLE.
- inA  input  WIDTH  operand A / shift source.
- inB  input  WIDTH  operand B (add/sub only).
- inC  input  SHW  shift amount (shift ops only).
- op  input  2  operation select.
- out_valid  output  1  response valid.
- out_ready  input  1  response accepted by consumer.
- ans  output  WIDTH  result.
- cout  output  1  carry (add), borrow (sub), last bit shifted out (shifts).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n low forces reset immediately, independent of clk).
- Reset values: state=IDLE, ans=0, cout=0, out_valid=0, in_ready=1, shift counter=0. Requests are never accepted while rst_n is low.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid&&in_ready on a rising edge. Operands are captured at that edge; later input changes have no effect.
- IDLE transitions on accept:
  - op=11: {cout,ans} <= inA+inB (WIDTH+1-bit sum); go to DONE.
  - op=10: ans <= (inA-inB) mod 2^WIDTH; cout <= (inA<inB) unsigned; go to DONE.
  - op=0x with inC==0: ans <= inA, cout <= 0; go to DONE.
  - op=0x with inC=n>0: acc <= inA, cnt <= n, cout <= 0; go to SHIFT.
- SHIFT, each edge:
  - acc shifts right by 1; fill bit is acc[MSB] for op=00, 0 for op=01.
  - cout <= bit shifted out (acc[0] before the shift).
  - cnt decrements; when cnt==1 before the decrement, go to DONE.
- DONE:
  - ans and cout stay stable until the handshake.
  - On out_valid&&out_ready at an edge, go to IDLE. in_ready rises the following cycle.
  - There is no same-cycle re-accept. Throughput is at most one op per latency+1 cycles.
- Latency, measured in edges from the accept edge to the first cycle with out_valid=1:
  - 1 for add, sub and zero-length shifts.
  - 1+n for a shift of n.
- ans is driven from the acc register (ans==acc at all times).
- op is registered for the duration of SHIFT.
- Reset mid-operation (SHIFT or DONE): abort immediately; all outputs return to reset values; the pending result is discarded.
- in_valid while not ready is ignored; no queuing.
- An unknown op cannot occur; all four codes are defined.

Decomposition:
- Shared package alu_pkg:
  - op constants OP_SRA=2'b00, OP_SRL=2'b01, OP_SUB=2'b10, OP_ADD=2'b11.
  - state enum {IDLE, SHIFT, DONE}.
- One combinational sub-module, alu_shift_step. Inputs: acc, arith flag. Outputs: shifted value, out bit. Instantiated once in the SHIFT datapath.
- The add/sub datapath is inline.

Test Plan (WIDTH=4, SHW=2):
- Reset: hold rst_n low 3 cycles with in_valid=1 -> ans=0, cout=0, out_valid=0, no accept. Release -> in_ready=1.
- Add: inA=4'hB, inB=4'h7, op=11 -> ans=4'h2, cout=1, out_valid high 1 cycle after accept. Sub: inA=3, inB=5, op=10 -> ans=4'hE, cout=1.
- Arithmetic shift: inA=4'b1000, inC=3, op=00 -> ans=4'b1111, cout=0, out_valid 4 cycles after accept, in_ready=0 throughout.
- Logical shift: inA=4'b1011, inC=2, op=01 -> ans=4'b0010, cout=1, latency 3. Zero shift: inA=4'h9, inC=0 -> ans=4'h9, cout=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving new in_valid requests -> ans and cout stable, in_ready=0, requests ignored. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- Reset mid-shift: assert rst_n low during SHIFT (inC=3, after 1 step), asynchronous to clk -> outputs clear at once. After release: no stale out_valid, and a fresh add returns the correct result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq command unit: op encoding and FSM states.
package alu_pkg;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the alu_seq unit. The producer/consumer side uses
// the master modport, the ALU itself uses the slave modport.
interface alu_seq_if #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [SHW-1:0]   inC;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic             cout;

  modport master (
    output in_valid, inA, inB, inC, op, out_ready,
    input  in_ready, out_valid, ans, cout
  );

  modport slave (
    input  in_valid, inA, inB, inC, op, out_ready,
    output in_ready, out_valid, ans, cout
  );

endinterface

// File: rtl/alu_shift_step.sv
// One-bit right shift step: arithmetic (sign fill) or logical (zero fill),
// also reporting the bit that falls off the bottom.
module alu_shift_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  logic fill_s;

  // Fill bit is the sign for arithmetic shifts, zero otherwise.
  always_comb begin
    if (arith) begin
      fill_s = acc[WIDTH-1];
    end else begin
      fill_s = 1'b0;
    end
  end

  assign shifted = {fill_s, acc[WIDTH-1:1]};
  assign out_bit = acc[0];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle handshaked ALU: single-step add/sub, iterative one-bit-per-clock
// shifts, with a carry/borrow/shift-out flag. The result is held until the
// consumer takes it; no new request is accepted until then.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             cout_r;
  logic             cout_nxt_s;
  logic [SHW-1:0]   cnt_r;
  logic [SHW-1:0]   cnt_nxt_s;
  logic [1:0]       op_r;
  logic [1:0]       op_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] shift_val_s;
  logic             shift_out_s;
  logic             arith_s;

  // Extra top bit holds carry for the sum and borrow for the difference.
  assign sum_s   = {1'b0, bus.inA} + {1'b0, bus.inB};
  assign diff_s  = {1'b0, bus.inA} - {1'b0, bus.inB};
  assign arith_s = (op_r == OP_SRA);

  alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .acc     (acc_r),
    .arith   (arith_s),
    .shifted (shift_val_s),
    .out_bit (shift_out_s)
  );

  // Next-state and datapath update selection for the command FSM.
  always_comb begin
    next_state_s = state_r;
    acc_nxt_s    = acc_r;
    cout_nxt_s   = cout_r;
    cnt_nxt_s    = cnt_r;
    op_nxt_s     = op_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.op)
            OP_ADD: begin
              {cout_nxt_s, acc_nxt_s} = sum_s;
              next_state_s            = DONE;
            end
            OP_SUB: begin
              acc_nxt_s    = diff_s[WIDTH-1:0];
              cout_nxt_s   = diff_s[WIDTH];
              next_state_s = DONE;
            end
            OP_SRA, OP_SRL: begin
              acc_nxt_s  = bus.inA;
              cout_nxt_s = 1'b0;
              op_nxt_s   = bus.op;
              if (bus.inC == {SHW{1'b0}}) begin
                next_state_s = DONE;
              end else begin
                cnt_nxt_s    = bus.inC;
                next_state_s = SHIFT;
              end
            end
            default: begin
              next_state_s = IDLE;
            end
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        acc_nxt_s  = shift_val_s;
        cout_nxt_s = shift_out_s;
        cnt_nxt_s  = cnt_r - SHW'(1);
        if (cnt_r == SHW'(1)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; reset aborts any op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      cnt_r       <= {SHW{1'b0}};
      op_r        <= 2'b00;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      acc_r       <= acc_nxt_s;
      cout_r      <= cout_nxt_s;
      cnt_r       <= cnt_nxt_s;
      op_r        <= op_nxt_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  assign bus.ans       = acc_r;
  assign bus.cout      = cout_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference.
module tb_alu_seq;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_seq_if #(.WIDTH(W), .SHW(S)) bif ();

  alu_seq #(.WIDTH(W), .SHW(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result, flag and latency straight from the op definitions.
  task automatic model(input int a, input int b, input int c, input int o,
                       output int ea, output int ec, output int el);
    int sa;
    case (o)
      3: begin ea = (a + b) & MASK; ec = (a + b) >> W; el = 1; end
      2: begin ea = (a - b) & MASK; ec = (a < b) ? 1 : 0; el = 1; end
      default: begin
        if (c == 0) begin
          ea = a; ec = 0; el = 1;
        end else begin
          if (o == 0) begin
            sa = (a >= HALF) ? a - (1 << W) : a;
            ea = (sa >>> c) & MASK;
          end else begin
            ea = a >> c;
          end
          ec = (a >> (c - 1)) & 1;
          el = 1 + c;
        end
      end
    endcase
  endtask

  // Issue one op, check result/latency, hold backpressure for 'hold' cycles.
  task automatic do_op(input int a, input int b, input int c, input int o, input int hold);
    int  ea, ec, el, lat;
    bit  seen;
    model(a, b, c, o, ea, ec, el);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bif.in_ready) begin seen = 1'b1; break; end
    end
    if (!seen) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    bif.in_valid = 1'b1;
    bif.inA = W'(a);
    bif.inB = W'(b);
    bif.inC = S'(c);
    bif.op  = 2'(o);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    bif.inA = W'($urandom);
    bif.inB = W'($urandom);
    bif.inC = S'($urandom);
    bif.op  = 2'($urandom);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      lat++;
      if (bif.out_valid) begin seen = 1'b1; break; end
      chk("busy_in_ready", 32'(bif.in_ready), 32'd0);
    end
    if (!seen) begin chk("done_timeout", 32'd0, 32'd1); return; end
    chk("latency", 32'(lat), 32'(el));
    chk("ans", 32'(bif.ans), 32'(ea));
    chk("cout", 32'(bif.cout), 32'(ec));
    chk("done_in_ready", 32'(bif.in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      bif.in_valid = 1'b1;
      bif.inA = W'($urandom);
      bif.inB = W'($urandom);
      bif.op  = 2'($urandom);
      @(negedge clk);
      chk("hold_ans", 32'(bif.ans), 32'(ea));
      chk("hold_cout", 32'(bif.cout), 32'(ec));
      chk("hold_valid", 32'(bif.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bif.in_ready), 32'd0);
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(negedge clk);
    bif.out_ready = 1'b0;
    chk("post_valid", 32'(bif.out_valid), 32'd0);
    chk("post_in_ready", 32'(bif.in_ready), 32'd1);
  endtask

  // Main stimulus sequence.
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b0;
    bif.inA = 4'hB;
    bif.inB = 4'h7;
    bif.inC = 2'd0;
    bif.op  = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ans", 32'(bif.ans), 32'd0);
      chk("rst_cout", 32'(bif.cout), 32'd0);
      chk("rst_valid", 32'(bif.out_valid), 32'd0);
    end
    bif.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rel_valid", 32'(bif.out_valid), 32'd0);

    // Directed cases.
    do_op(4'hB, 4'h7, 0, 3, 0);
    do_op(3, 5, 0, 2, 0);
    do_op(4'b1000, 0, 3, 0, 0);
    do_op(4'b1011, 0, 2, 1, 0);
    do_op(4'h9, 0, 0, 0, 0);
    do_op(4'h6, 4'h6, 0, 2, 5);
    do_op(4'hF, 4'h1, 0, 3, 0);
    do_op(4'h7, 0, 3, 0, 2);

    // Reset in the middle of a shift.
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.inA = 4'b1000;
    bif.inC = 2'd3;
    bif.op  = 2'b00;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ans", 32'(bif.ans), 32'd0);
    chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
    chk("mid_rst_cout", 32'(bif.cout), 32'd0);
    chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(bif.out_valid), 32'd0);
    end
    do_op(4'h5, 4'h4, 0, 3, 0);

    // Randomized ops with random backpressure.
    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)),
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
